binary_add_14_checker: RTL and testbench

Self-checking stimulus generator and response checker that sits on the driving side of the registered 14-bit adder (`A`, `B`, `en` in; `S` out). It sweeps every operand pair in a programmable range, one vector per clock. It compares each registered sum against its own modular reference and reports a pass/fail verdict, a saturating error count and the first failing vector. It replaces the simulation-only exhaustive bench with synthesizable logic usable on silicon or FPGA bring-up.

---
 rtl/binary_add_14_checker.sv | 201 ++++++++++++++++++++
 tb/tb_binary_add_14_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_add_14_checker.sv
// -----------------------------------------------------------------------------
// binary_add_14_checker
//
// Synthesizable stimulus generator and response checker for a registered
// W-bit adder (A, B, en in; S out). One accepted start sweeps every operand
// pair (A = 0..A_MAX outer, B = 0..B_MAX inner), one vector per clock. Each
// DUT sum is compared, LAT cycles after issue, against (a + b) mod 2^W.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   start        one-cycle sweep request; honoured only when idle
//   dut_a/dut_b  registered operands to the DUT
//   dut_en       registered operand-valid / DUT enable
//   dut_s        DUT sum, compared combinationally at the reference tail
//   busy         high while the sweep and its drain are in progress
//   done         one-cycle pulse at sweep end
//   pass         verdict of the last sweep (valid from done to next start)
//   err_count    saturating mismatch count of the current/last sweep
//   first_err_*  operands and DUT sum of the first mismatch of the sweep
// -----------------------------------------------------------------------------
module binary_add_14_checker #(
  parameter int          W     = 14,
  parameter int          LAT   = 1,
  parameter int unsigned A_MAX = (32'd1 << W) - 32'd1,
  parameter int unsigned B_MAX = (32'd1 << W) - 32'd1,
  parameter int          ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     dut_a,
  output logic [W-1:0]     dut_b,
  output logic             dut_en,
  input  logic [W-1:0]     dut_s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [W-1:0]     first_err_a,
  output logic [W-1:0]     first_err_b,
  output logic [W-1:0]     first_err_s
);

  localparam logic [W-1:0] A_LAST     = W'(A_MAX);
  localparam logic [W-1:0] B_LAST     = W'(B_MAX);
  localparam logic [2:0]   DRAIN_LAST = 3'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t     state, state_nxt;
  logic       start_ok;
  logic       last_pair;
  logic       drain_end;
  logic [2:0] drain_cnt;

  // Reference pipeline: entry i is the vector issued i+1 cycles ago.
  logic         pipe_v [LAT];
  logic [W-1:0] pipe_a [LAT];
  logic [W-1:0] pipe_b [LAT];
  logic [W-1:0] pipe_x [LAT];
  logic [W-1:0] sum_ref;
  logic         mismatch;

  assign last_pair = (dut_a == A_LAST) && (dut_b == B_LAST);
  assign drain_end = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);
  // Carry is dropped by the W-bit destination: modular reference sum.
  assign sum_ref   = dut_a + dut_b;
  assign mismatch  = pipe_v[LAT-1] && (dut_s != pipe_x[LAT-1]);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first; a path that left one
    // unassigned would infer a latch.
    state_nxt = state;
    start_ok  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_pair) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand generator: B inner, A outer. Operands hold through the drain.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_a     <= '0;
      dut_b     <= '0;
      dut_en    <= 1'b0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            dut_a  <= '0;
            dut_b  <= '0;
            dut_en <= 1'b1;
          end
        end
        S_RUN: begin
          if (last_pair) begin
            dut_en    <= 1'b0;
            drain_cnt <= '0;
          end else if (dut_b == B_LAST) begin
            dut_b <= '0;
            dut_a <= dut_a + W'(1);
          end else begin
            dut_b <= dut_b + W'(1);
          end
        end
        S_DRAIN: drain_cnt <= drain_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Reference pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= dut_en;
      for (int i = 1; i < LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // NOTE: the payload stages carry no reset; they are only looked at when the
  // matching valid bit (which is reset) is set.
  always_ff @(posedge clk) begin
    pipe_a[0] <= dut_a;
    pipe_b[0] <= dut_b;
    pipe_x[0] <= sum_ref;
    for (int i = 1; i < LAT; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
      pipe_x[i] <= pipe_x[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Result tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      err_count   <= '0;
      pass        <= 1'b0;
      first_err_a <= '0;
      first_err_b <= '0;
      first_err_s <= '0;
    end else begin
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
        // err_count only grows within a sweep, so zero marks "no error yet".
        if (err_count == '0) begin
          first_err_a <= pipe_a[LAT-1];
          first_err_b <= pipe_b[LAT-1];
          first_err_s <= dut_s;
        end
      end
      // The final compare lands in the last drain cycle; fold it in here.
      if (drain_end) pass <= (err_count == '0) && !mismatch;
    end
  end

endmodule

// File: tb/tb_binary_add_14_checker.sv
// -----------------------------------------------------------------------------
// tb_binary_add_14_checker
//
// Two checker instances, each driving a behavioural adder model:
//   sel 0: W=14, LAT=1, 4x4 sweep, 16-bit error counter
//   sel 1: W=4,  LAT=3, 16x16 sweep (every carry-out case), 2-bit counter
// Adder faults are injected through a per-vector XOR mask. The expected
// verdict, count and first failing vector are derived by walking the sweep
// order with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_binary_add_14_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic go;
  int   sel;
  logic start0, start1;

  logic [13:0] mask [256];

  // ---- instance 0 ----
  logic [13:0] a0_a, a0_b, a0_s, a0_fa, a0_fb, a0_fs;
  logic        a0_en, a0_busy, a0_done, a0_pass;
  logic [15:0] a0_err;

  binary_add_14_checker #(.W(14), .LAT(1), .A_MAX(3), .B_MAX(3), .ERR_W(16)) u_chk0 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(a0_a), .dut_b(a0_b), .dut_en(a0_en), .dut_s(a0_s),
    .busy(a0_busy), .done(a0_done), .pass(a0_pass), .err_count(a0_err),
    .first_err_a(a0_fa), .first_err_b(a0_fb), .first_err_s(a0_fs)
  );

  // Registered adder, latency 1.
  always @(posedge clk)
    if (a0_en) a0_s <= (a0_a + a0_b) ^ mask[int'(a0_a) * 4 + int'(a0_b)];

  // ---- instance 1 ----
  logic [3:0] b1_a, b1_b, b1_s, b1_fa, b1_fb, b1_fs, p1, p2;
  logic       b1_en, b1_busy, b1_done, b1_pass;
  logic [1:0] b1_err;

  binary_add_14_checker #(.W(4), .LAT(3), .A_MAX(15), .B_MAX(15), .ERR_W(2)) u_chk1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(b1_a), .dut_b(b1_b), .dut_en(b1_en), .dut_s(b1_s),
    .busy(b1_busy), .done(b1_done), .pass(b1_pass), .err_count(b1_err),
    .first_err_a(b1_fa), .first_err_b(b1_fb), .first_err_s(b1_fs)
  );

  // Three-stage adder, latency 3.
  always @(posedge clk) begin
    if (b1_en) p1 <= (b1_a + b1_b) ^ mask[int'(b1_a) * 16 + int'(b1_b)][3:0];
    p2   <= p1;
    b1_s <= p2;
  end

  // ---- monitor mux ----
  logic [13:0] m_a, m_b, m_fa, m_fb, m_fs;
  logic        m_en, m_busy, m_done, m_pass;
  logic [15:0] m_err;

  always_comb begin
    start0 = go && (sel == 0);
    start1 = go && (sel == 1);
    if (sel == 0) begin
      m_a = a0_a;  m_b = a0_b;  m_en = a0_en;  m_busy = a0_busy;
      m_done = a0_done;  m_pass = a0_pass;  m_err = a0_err;
      m_fa = a0_fa;  m_fb = a0_fb;  m_fs = a0_fs;
    end else begin
      m_a = 14'(b1_a);  m_b = 14'(b1_b);  m_en = b1_en;  m_busy = b1_busy;
      m_done = b1_done;  m_pass = b1_pass;  m_err = 16'(b1_err);
      m_fa = 14'(b1_fa);  m_fb = 14'(b1_fb);  m_fs = 14'(b1_fs);
    end
  end

  // ---- checking ----
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(m_busy), 0);
    check({tag, "_en"},   32'(m_en),   0);
    check({tag, "_a"},    32'(m_a),    0);
    check({tag, "_b"},    32'(m_b),    0);
    check({tag, "_done"}, 32'(m_done), 0);
    check({tag, "_pass"}, 32'(m_pass), 0);
    check({tag, "_err"},  32'(m_err),  0);
    check({tag, "_fa"},   32'(m_fa),   0);
    check({tag, "_fb"},   32'(m_fb),   0);
    check({tag, "_fs"},   32'(m_fs),   0);
  endtask

  // One full sweep on instance s; mid_at >= 0 pulses start during the run.
  task automatic run(input int s, input int amax, input int bmax, input int lat,
                     input int w, input int mid_at);
    int n, errmax, wm, nerr, fa, fb, fs, exp_err;
    int vec, seq_bad, cyc;
    bit seen;
    n      = (amax + 1) * (bmax + 1);
    errmax = (s == 0) ? 65535 : 3;
    wm     = (1 << w) - 1;
    nerr = 0; fa = 0; fb = 0; fs = 0;
    for (int i = 0; i < n; i++) begin
      int a, b, e, g;
      a = i / (bmax + 1);
      b = i % (bmax + 1);
      e = (a + b) % (1 << w);
      g = (e ^ int'(mask[i])) & wm;
      if (g != e) begin
        if (nerr == 0) begin fa = a; fb = b; fs = g; end
        nerr++;
      end
    end
    exp_err = (nerr > errmax) ? errmax : nerr;

    sel = s;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    // First vector cycle: results from the previous sweep are cleared.
    check("start_busy", 32'(m_busy), 1);
    check("start_err",  32'(m_err),  0);
    check("start_pass", 32'(m_pass), 0);
    check("start_fa",   32'(m_fa),   0);

    vec = 0; seq_bad = 0; cyc = 0; seen = 1'b0;
    while (cyc < n + lat + 20) begin
      if (m_done) begin seen = 1'b1; break; end
      if (!m_busy) seq_bad++;
      if (m_en) begin
        if (int'(m_a) != vec / (bmax + 1) || int'(m_b) != vec % (bmax + 1)) seq_bad++;
        vec++;
      end else begin
        if (vec < n) seq_bad++;
        if (int'(m_a) != amax || int'(m_b) != bmax) seq_bad++;
      end
      if (cyc == mid_at) go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      cyc++;
    end
    check("done_seen",  32'(seen),    1);
    // done falls in cycle N+LAT counting the first vector cycle as cycle 0,
    // i.e. the (N+LAT+1)-th cycle of the sweep.
    check("done_cycle", 32'(cyc),     32'(n + lat));
    check("vectors",    32'(vec),     32'(n));
    check("seq_errors", 32'(seq_bad), 0);
    check("done_busy",  32'(m_busy),  0);
    check("pass",       32'(m_pass),  32'(nerr == 0));
    check("err_count",  32'(m_err),   32'(exp_err));
    check("first_a",    32'(m_fa),    32'(fa));
    check("first_b",    32'(m_fb),    32'(fb));
    check("first_s",    32'(m_fs),    32'(fs));
    // A start in the done cycle must be ignored.
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("fin_start_busy", 32'(m_busy), 0);
    check("fin_start_en",   32'(m_en),   0);
    check("done_pulse",     32'(m_done), 0);
    check("pass_held",      32'(m_pass), 32'(nerr == 0));
    check("err_held",       32'(m_err),  32'(exp_err));
  endtask

  task automatic set_masks(input int kind, input int bmax, input int n, input int wm);
    for (int i = 0; i < 256; i++) mask[i] = '0;
    for (int i = 0; i < n; i++) begin
      int e;
      e = (i / (bmax + 1) + i % (bmax + 1)) & wm;
      case (kind)
        1: mask[i] = 14'(e & 1);                 // S[0] stuck at 0
        2: mask[i] = 14'(e ^ wm);                // S forced to all ones
        3: mask[i] = ($urandom_range(0, 2) == 0) ? 14'($urandom_range(1, wm)) : 14'd0;
        default: mask[i] = '0;
      endcase
    end
  endtask

  initial begin
    int dones;
    for (int i = 0; i < 256; i++) mask[i] = '0;
    go  = 1'b0;
    sel = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check_idle_outputs("reset");
    end
    @(negedge clk);

    // Instance 0: W=14, LAT=1, 4x4.
    set_masks(0, 3, 16, 16383);
    run(0, 3, 3, 1, 14, $urandom_range(1, 14));
    set_masks(1, 3, 16, 16383);
    run(0, 3, 3, 1, 14, -1);
    for (int k = 0; k < 3; k++) begin
      set_masks(3, 3, 16, 16383);
      run(0, 3, 3, 1, 14, $urandom_range(0, 14));
    end

    // Instance 1: W=4, LAT=3, full 16x16 (covers every wrapping sum).
    set_masks(0, 15, 256, 15);
    run(1, 15, 15, 3, 4, $urandom_range(1, 250));
    set_masks(2, 15, 256, 15);
    run(1, 15, 15, 3, 4, -1);
    set_masks(3, 15, 256, 15);
    run(1, 15, 15, 3, 4, -1);

    // Reset mid-run on instance 0 with errors already accumulated.
    set_masks(2, 3, 16, 16383);
    sel = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_err_nonzero", 32'(m_err != 0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("mid_rst");
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_done || m_busy) dones++;
      @(negedge clk);
    end
    check("no_done_after_rst", 32'(dones), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
